// File: rtl/camera_send_pic_pkg.sv
// Timing defaults, address width and FSM state encoding shared by the DVP frame sender.
package camera_send_pic_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_H_BLANK  = 144;
   localparam int DEF_VS_LOW   = 16;
   localparam int DEF_V_BACK   = 32;
   localparam int ADDR_W       = 19;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VS_GAP,
      S_V_BACK,
      S_LINE_ACT,
      S_LINE_BLANK
   } state_t;

endpackage

// File: rtl/camera_send_pic_rgb565.sv
// RGB444 -> RGB565 widening by replicating MSBs into the new LSBs; purely combinational.
module rgb444_to_rgb565 (
   input  logic [11:0] rgb444,
   output logic [15:0] rgb565
);

   logic [3:0] r4;
   logic [3:0] g4;
   logic [3:0] b4;

   assign r4 = rgb444[11:8];
   assign g4 = rgb444[7:4];
   assign b4 = rgb444[3:0];

   // Receiver taking [15:12],[10:7],[4:1] gets the original nibbles back.
   assign rgb565 = {r4, r4[3], g4, g4[3:2], b4, b4[3]};

endmodule

// File: rtl/camera_send_pic.sv
// DVP frame sender: streams a buffered RGB444 frame as RGB565 bytes with vsync/href timing.
// Reads are issued two cycles ahead of the high byte; no backpressure, the stream free-runs while en is high.
module camera_send_pic
   import camera_send_pic_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int H_BLANK  = DEF_H_BLANK,
   parameter int VS_LOW   = DEF_VS_LOW,
   parameter int V_BACK   = DEF_V_BACK
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic              vsync,
   output logic              href,
   output logic [7:0]        data_out,
   output logic              frame_done
);

   localparam int BYTE_W  = $clog2(2 * H_ACTIVE);
   localparam int LINE_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int GAP_MX1 = (VS_LOW > V_BACK) ? VS_LOW : V_BACK;
   localparam int GAP_MAX = (GAP_MX1 > H_BLANK) ? GAP_MX1 : H_BLANK;
   localparam int GAP_W   = $clog2(GAP_MAX + 1);

   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(2 * H_ACTIVE - 1);
   localparam logic [BYTE_W-1:0] BYTE_PREF = BYTE_W'(2 * H_ACTIVE - 2);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [GAP_W-1:0]  VS_LAST   = GAP_W'(VS_LOW - 1);
   localparam logic [GAP_W-1:0]  VB_LAST   = GAP_W'(V_BACK - 1);
   localparam logic [GAP_W-1:0]  VB_PREF   = GAP_W'(V_BACK - 2);
   localparam logic [GAP_W-1:0]  HB_LAST   = GAP_W'(H_BLANK - 1);
   localparam logic [GAP_W-1:0]  HB_PREF   = GAP_W'(H_BLANK - 2);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   state_t            state, nxt_state;
   logic [GAP_W-1:0]  gap_cnt, nxt_gap;
   logic [BYTE_W-1:0] byte_cnt, nxt_byte;
   logic [LINE_W-1:0] line_cnt, nxt_line;
   logic              frame_end;
   logic              fetch;
   logic [15:0]       rgb565;
   logic [7:0]        lo_byte;

   rgb444_to_rgb565 u_conv (
      .rgb444 (rd_data),
      .rgb565 (rgb565)
   );

   always_comb begin
      nxt_state = state;
      nxt_gap   = gap_cnt;
      nxt_byte  = byte_cnt;
      nxt_line  = line_cnt;
      frame_end = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               nxt_state = S_VS_GAP;
               nxt_gap   = '0;
            end
         end
         S_VS_GAP: begin
            if (gap_cnt == VS_LAST) begin
               nxt_state = S_V_BACK;
               nxt_gap   = '0;
            end else begin
               nxt_gap = gap_cnt + 1'b1;
            end
         end
         S_V_BACK: begin
            if (gap_cnt == VB_LAST) begin
               nxt_state = S_LINE_ACT;
               nxt_byte  = '0;
               nxt_line  = '0;
            end else begin
               nxt_gap = gap_cnt + 1'b1;
            end
         end
         S_LINE_ACT: begin
            if (byte_cnt == BYTE_LAST) begin
               nxt_byte = '0;
               nxt_gap  = '0;
               if (line_cnt == LINE_LAST) begin
                  frame_end = 1'b1;
                  nxt_line  = '0;
                  nxt_state = en ? S_VS_GAP : S_IDLE;
               end else begin
                  nxt_line  = line_cnt + 1'b1;
                  nxt_state = S_LINE_BLANK;
               end
            end else begin
               nxt_byte = byte_cnt + 1'b1;
            end
         end
         S_LINE_BLANK: begin
            if (gap_cnt == HB_LAST) begin
               nxt_state = S_LINE_ACT;
               nxt_byte  = '0;
            end else begin
               nxt_gap = gap_cnt + 1'b1;
            end
         end
         default: nxt_state = S_IDLE;
      endcase
      // Read strobe lands two cycles before the high byte it feeds.
      fetch = ((nxt_state == S_LINE_ACT) && !nxt_byte[0] && (nxt_byte < BYTE_PREF)) ||
              ((nxt_state == S_V_BACK) && (nxt_gap == VB_PREF)) ||
              ((nxt_state == S_LINE_BLANK) && (nxt_gap == HB_PREF));
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         gap_cnt    <= '0;
         byte_cnt   <= '0;
         line_cnt   <= '0;
         vsync      <= 1'b0;
         href       <= 1'b0;
         data_out   <= '0;
         lo_byte    <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         gap_cnt    <= nxt_gap;
         byte_cnt   <= nxt_byte;
         line_cnt   <= nxt_line;
         vsync      <= nxt_state inside {S_V_BACK, S_LINE_ACT, S_LINE_BLANK};
         href       <= (nxt_state == S_LINE_ACT);
         rd_en      <= fetch;
         frame_done <= frame_end;
         if (nxt_state == S_VS_GAP) begin
            rd_addr <= '0;
         end else if (rd_en) begin
            rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + 1'b1;
         end
         if (nxt_state == S_LINE_ACT) begin
            if (!nxt_byte[0]) begin
               data_out <= rgb565[15:8];
               lo_byte  <= rgb565[7:0];
            end else begin
               data_out <= lo_byte;
            end
         end else begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_camera_send_pic.sv
// Directed bench for camera_send_pic at a 4x2 frame with short blanking.
module tb_camera_send_pic;

   logic        pclk = 1'b0;
   logic        rst;
   logic        en;
   logic        rd_en;
   logic [18:0] rd_addr;
   logic [11:0] rd_data = '0;
   logic        vsync;
   logic        href;
   logic [7:0]  data_out;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic       vs_tr [0:127];
   logic       hr_tr [0:127];
   logic       re_tr [0:127];
   logic       fd_tr [0:127];
   logic [18:0] ra_tr [0:127];
   logic [7:0] do_tr [0:127];

   camera_send_pic #(
      .H_ACTIVE (4),
      .V_ACTIVE (2),
      .H_BLANK  (3),
      .VS_LOW   (2),
      .V_BACK   (2)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .en         (en),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .vsync      (vsync),
      .href       (href),
      .data_out   (data_out),
      .frame_done (frame_done)
   );

   always #5 pclk = ~pclk;

   function automatic logic [11:0] pix(input int i);
      if (i == 0) return 12'hF0A;
      return {4'(i), 4'(15 - i), 4'(3 * i)};
   endfunction

   function automatic logic [15:0] exp565(input logic [11:0] p);
      int r, g, b;
      r = int'(p[11:8]);
      g = int'(p[7:4]);
      b = int'(p[3:0]);
      return 16'((r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8));
   endfunction

   // Synchronous frame buffer: data appears the cycle after the strobe.
   always @(posedge pclk) begin
      if (rd_en) rd_data <= pix(int'(rd_addr[2:0]));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic rec(input int c);
      vs_tr[c] = vsync;
      hr_tr[c] = href;
      re_tr[c] = rd_en;
      fd_tr[c] = frame_done;
      ra_tr[c] = rd_addr;
      do_tr[c] = data_out;
   endtask

   initial begin
      int cnt;
      int base;
      int s;
      int rc;
      logic [15:0] e;
      logic [7:0]  hi, lo;
      logic [11:0] recon;

      rst = 1'b0;
      en  = 1'b0;
      repeat (2) @(negedge pclk);
      chk("rst_vsync", vsync, 0);
      chk("rst_href", href, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_frame_done", frame_done, 0);

      rst = 1'b1;
      repeat (3) @(negedge pclk);
      chk("idle_outs", {vsync, href, rd_en, frame_done}, 0);
      chk("idle_addr", rd_addr, 0);

      en = 1'b1;
      for (int c = 1; c <= 87; c++) begin
         @(negedge pclk);
         rec(c);
         if (c == 53) en = 1'b0;
         if (c == 80) en = 1'b1;
      end
      chk("mid_line_href", hr_tr[87], 1);

      #2 rst = 1'b0;
      #1;
      chk("arst_outs", {vsync, href, rd_en, frame_done, data_out, rd_addr}, 0);
      @(negedge pclk);
      rst = 1'b1;
      for (int c = 101; c <= 108; c++) begin
         @(negedge pclk);
         rec(c);
      end

      // Frames 1 and 2 back-to-back, 23-cycle period.
      for (int f = 0; f < 2; f++) begin
         base = 23 * f;
         chk("vs_gap_low", vs_tr[base + 2], 0);
         chk("vs_rise", vs_tr[base + 3], 1);
         for (int l = 0; l < 2; l++) begin
            s = 5 + base + 11 * l;
            chk("href_pre", hr_tr[s - 1], 0);
            cnt = 0;
            for (int k = 0; k < 8; k++) cnt += int'(hr_tr[s + k]);
            chk("href_len", cnt, 8);
            chk("href_post", hr_tr[s + 8], 0);
         end
         for (int p = 0; p < 8; p++) begin
            rc = base + ((p < 4) ? (3 + 2 * p) : (14 + 2 * (p - 4)));
            e  = exp565(pix(p));
            hi = do_tr[rc + 2];
            lo = do_tr[rc + 3];
            recon = {hi[7:4], hi[2:0], lo[7], lo[4:1]};
            chk("rd_en_pix", re_tr[rc], 1);
            chk("rd_addr_pix", ra_tr[rc], p);
            chk("byte_hi", hi, e[15:8]);
            chk("byte_lo", lo, e[7:0]);
            chk("loopback", recon, pix(p));
         end
         cnt = 0;
         for (int c = base + 1; c <= base + 23; c++) cnt += int'(re_tr[c]);
         chk("rd_en_per_frame", cnt, 8);
      end

      chk("f0a_hi", do_tr[5], 8'hF8);
      chk("f0a_lo", do_tr[6], 8'h15);

      cnt = 0;
      for (int c = 1; c <= 23; c++) cnt += int'(!vs_tr[c]);
      chk("vs_low_cycles", cnt, 2);

      chk("fd_frame1", fd_tr[24], 1);
      chk("fd_frame2", fd_tr[47], 1);
      chk("fd_frame3", fd_tr[70], 1);
      cnt = 0;
      for (int c = 1; c <= 87; c++) cnt += int'(fd_tr[c]);
      chk("fd_count", cnt, 3);

      // Frame 3: en dropped during line 0, frame still completes.
      cnt = 0;
      for (int c = 47; c <= 69; c++) cnt += int'(hr_tr[c]);
      chk("en_drop_bytes", cnt, 16);
      chk("en_drop_vs70", vs_tr[70], 0);
      cnt = 0;
      for (int c = 70; c <= 80; c++) cnt += int'(vs_tr[c] | hr_tr[c] | re_tr[c]);
      chk("idle_after_drop", cnt, 0);

      cnt = 0;
      for (int c = 1; c <= 87; c++) if (!hr_tr[c] && do_tr[c] != 8'h00) cnt++;
      chk("data_zero_blank", cnt, 0);

      // Restart after mid-line reset.
      chk("rst_vs_gap", vs_tr[101], 0);
      chk("rst_addr0", ra_tr[101], 0);
      chk("rst_vb_rise", vs_tr[103], 1);
      chk("rst_rd_en0", re_tr[103], 1);
      chk("rst_rd_addr0", ra_tr[103], 0);
      chk("rst_href_pre", hr_tr[104], 0);
      chk("rst_href_on", hr_tr[105], 1);
      chk("rst_first_byte", do_tr[105], 8'hF8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/camera_send_pic.md
CAMERA_SEND_PIC -- requirements
Module: camera_send_pic

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 Parameter H_BLANK, default 144, meaning pclk cycles with href low between lines.
REQ-004 Parameter VS_LOW, default 16, meaning pclk cycles with vsync low between frames.
REQ-005 Parameter V_BACK, default 32, meaning pclk cycles with vsync high and href low before line 0.
REQ-006 pclk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  level; high means frames are transmitted back-to-back.
REQ-009 rd_en  output  1  frame-buffer read strobe.
REQ-010 rd_addr  output  19  frame-buffer pixel address.
REQ-011 rd_data  input  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}, valid exactly 1 cycle after rd_en.
REQ-012 vsync  output  1  high during a frame; low during the inter-frame gap.
REQ-013 href  output  1  high while data_out carries active line bytes.
REQ-014 data_out  output  8  DVP byte stream, RGB565 high byte first.
REQ-015 frame_done  output  1  one-cycle pulse after the last byte of a frame.

Function
REQ-016 FSM states are IDLE, VS_GAP, V_BACK, LINE_ACT, LINE_BLANK; all outputs are registered.
REQ-017 IDLE: vsync=0, href=0, rd_en=0; the FSM enters VS_GAP on the first cycle en=1 is sampled.
REQ-018 VS_GAP: vsync=0 for VS_LOW cycles, rd_addr forced to 0, then V_BACK.
REQ-019 V_BACK: vsync=1, href=0 for V_BACK cycles, then LINE_ACT for line 0.
REQ-020 LINE_ACT: href=1 for exactly 2*H_ACTIVE consecutive cycles; even byte = RGB565[15:8], odd byte = RGB565[7:0].
REQ-021 Expansion: R5={R4,R4[3]}, G6={G4,G4[3:2]}, B5={B4,B4[3]}; a receiver taking bits [15:12],[10:7],[4:1] recovers the original RGB444 exactly.
REQ-022 rd_en for pixel k is asserted with rd_addr=k exactly 2 cycles before the high byte of pixel k is on data_out; rd_en is high for one cycle per pixel.
REQ-023 rd_addr increments by 1 per pixel across lines, from 0 to H_ACTIVE*V_ACTIVE-1, and wraps to 0 at every VS_GAP.
REQ-024 LINE_BLANK: href=0 for H_BLANK cycles, then LINE_ACT; after the last line, frame_done pulses for one cycle and the FSM goes to VS_GAP if en=1, else IDLE.
REQ-025 If en falls mid-frame, the current frame completes in full and IDLE follows; en has no effect inside a frame.
REQ-026 data_out is 0 whenever href=0.
REQ-027 Line and byte counters are sized with $clog2 of their parameters; the byte counter compares against 2*H_ACTIVE-1 without overflow.

Reset
REQ-028 While rst=0: state=IDLE, vsync=0, href=0, data_out=0, rd_en=0, rd_addr=0, frame_done=0, all counters 0.
REQ-029 Reset asserted mid-line takes effect immediately (asynchronously); after release, the next frame starts at VS_GAP with rd_addr=0.

Structure
REQ-030 The shared package holds the default timing constants (H_ACTIVE, V_ACTIVE, H_BLANK, VS_LOW, V_BACK), the 19-bit address width, and the state enumeration.
REQ-031 A combinational sub-module rgb444_to_rgb565 implements REQ-021; all other logic lives in camera_send_pic.

Verification
REQ-032 H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_LOW=2, V_BACK=2, en held 1 -> vsync low 2 cycles, then 2 lines of 8 href-high cycles separated by 3 href-low cycles; frame_done pulses once; the pattern repeats.
REQ-033 rd_data=12'hF0A at addr 0 -> data_out bytes 8'hF8 then 8'h15 (RGB565 16'hF815); a loopback receiver reconstructs 12'hF0A.
REQ-034 Buffer preloaded with addr value as data -> rd_addr sequence 0..7 in frame 1 and 0..7 again in frame 2; rd_en high once per pixel, 2 cycles before each high byte.
REQ-035 en dropped during line 0 -> frame completes with 16 active bytes, then IDLE with vsync=0, href=0, rd_en=0.
REQ-036 rst pulsed low mid-line -> all outputs 0 in the same cycle; after release with en=1, the frame restarts at VS_GAP with rd_addr=0.
REQ-037 Loopback into the capture block at default parameters -> 307200 writes per frame, write address 0..307199, and data identical to the buffer contents.
